// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and cycle/counter constants for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 32'd5;
    localparam int unsigned DIV_CYCLES_DEF  = 32'd10;
    localparam int unsigned CNT_W           = 32'd4;

endpackage

// File: rtl/mdu_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
interface mdu_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    modport master (output start, op, a, b, input hi, lo, busy);
    modport slave  (input start, op, a, b, output hi, lo, busy);
endinterface

// File: rtl/mdu_arith.sv
// Combinational product/quotient/remainder generation for the MDU.
// Multiply-accumulate ops are compiled in only when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi_cur,
    input  logic [31:0] lo_cur,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        wr_en
);

    logic [63:0] prod_sgn_s;
    logic [63:0] prod_uns_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic [31:0] num_s;
    logic [31:0] den_s;
    logic [31:0] den_safe_s;
    logic [31:0] quot_raw_s;
    logic [31:0] rem_raw_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_sgn_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_uns_s = {32'd0, a} * {32'd0, b};

    // Sign-magnitude divide: truncating quotient, remainder follows the dividend;
    // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    always_comb begin
        neg_a_s    = (op == OP_DIV) & a[31];
        neg_b_s    = (op == OP_DIV) & b[31];
        num_s      = neg_a_s ? (32'd0 - a) : a;
        den_s      = neg_b_s ? (32'd0 - b) : b;
        den_safe_s = (den_s == 32'd0) ? 32'd1 : den_s;
        quot_raw_s = num_s / den_safe_s;
        rem_raw_s  = num_s % den_safe_s;
        quot_s     = (neg_a_s ^ neg_b_s) ? (32'd0 - quot_raw_s) : quot_raw_s;
        rem_s      = neg_a_s ? (32'd0 - rem_raw_s) : rem_raw_s;
    end

    // Result select; a zero divisor leaves HI/LO untouched.
    always_comb begin
        hi_res = hi_cur;
        lo_res = lo_cur;
        wr_en  = 1'b0;
        case (op)
            OP_MULT: begin
                {hi_res, lo_res} = prod_sgn_s;
                wr_en            = 1'b1;
            end
            OP_MULTU: begin
                {hi_res, lo_res} = prod_uns_s;
                wr_en            = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                hi_res = rem_s;
                lo_res = quot_s;
                wr_en  = (b != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                {hi_res, lo_res} = {hi_cur, lo_cur} + prod_sgn_s;
                wr_en            = 1'b1;
            end
            OP_MADDU: begin
                {hi_res, lo_res} = {hi_cur, lo_cur} + prod_uns_s;
                wr_en            = 1'b1;
            end
            OP_MSUB: begin
                {hi_res, lo_res} = {hi_cur, lo_cur} - prod_sgn_s;
                wr_en            = 1'b1;
            end
            OP_MSUBU: begin
                {hi_res, lo_res} = {hi_cur, lo_cur} - prod_uns_s;
                wr_en            = 1'b1;
            end
`endif
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: IDLE/RUN FSM, busy counter and HI/LO registers.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU ops.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic  clk,
    input  logic  clr,
    mdu_if.slave  bus
);

    localparam logic [CNT_W-1:0] MUL_N   = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

    mdu_state_e       state_r;
    mdu_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      hi_nxt_r;
    logic [31:0]      lo_nxt_r;
    logic             wr_nxt_r;
    logic             busy_r;
    logic [31:0]      hi_res_s;
    logic [31:0]      lo_res_s;
    logic             wr_res_s;
    logic             is_mul_s;
    logic             is_div_s;
    logic             is_mthi_s;
    logic             is_mtlo_s;
    logic             launch_s;
    logic             commit_s;
    logic             idle_start_s;

    mdu_arith u_arith (
        .op     (bus.op),
        .a      (bus.a),
        .b      (bus.b),
        .hi_cur (hi_r),
        .lo_cur (lo_r),
        .hi_res (hi_res_s),
        .lo_res (lo_res_s),
        .wr_en  (wr_res_s)
    );

    // Op decode; undefined codes decode to nothing.
    always_comb begin
        is_mul_s  = 1'b0;
        is_div_s  = 1'b0;
        is_mthi_s = 1'b0;
        is_mtlo_s = 1'b0;
        case (bus.op)
            OP_MULT, OP_MULTU: is_mul_s = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul_s = 1'b1;
`endif
            OP_DIV, OP_DIVU: is_div_s  = 1'b1;
            OP_MTHI:         is_mthi_s = 1'b1;
            OP_MTLO:         is_mtlo_s = 1'b1;
            default:         is_mul_s  = 1'b0;
        endcase
    end

    assign idle_start_s = (state_r == ST_IDLE) && bus.start;

    // Next-state logic: launch from IDLE, commit when the counter reaches one.
    always_comb begin
        state_nxt_s = state_r;
        launch_s    = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && (is_mul_s || is_div_s)) begin
                    state_nxt_s = ST_RUN;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_IDLE;
                    commit_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counter, pending result and busy flag.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r    <= '0;
            hi_nxt_r <= 32'd0;
            lo_nxt_r <= 32'd0;
            wr_nxt_r <= 1'b0;
            busy_r   <= 1'b0;
        end else if (launch_s) begin
            cnt_r    <= is_mul_s ? MUL_N : DIV_N;
            hi_nxt_r <= hi_res_s;
            lo_nxt_r <= lo_res_s;
            wr_nxt_r <= wr_res_s;
            busy_r   <= 1'b1;
        end else if (state_r == ST_RUN) begin
            cnt_r    <= cnt_r - CNT_ONE;
            busy_r   <= ~commit_s;
        end else begin
            busy_r   <= 1'b0;
        end
    end

    // HI/LO architectural registers: atomic commit or single-cycle moves.
    always_ff @(posedge clk) begin
        if (clr) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (commit_s && wr_nxt_r) begin
            hi_r <= hi_nxt_r;
            lo_r <= lo_nxt_r;
        end else if (idle_start_s && is_mthi_s) begin
            hi_r <= bus.a;
        end else if (idle_start_s && is_mtlo_s) begin
            lo_r <= bus.a;
        end else begin
            hi_r <= hi_r;
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = busy_r;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus random ops against an arithmetic model.
module tb_mdu;
    import mdu_pkg::*;

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic clk;
    logic clr;
    mdu_if bus ();

    int tests = 0;
    int fails = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    mdu dut (.clk(clk), .clr(clr), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    always @(posedge clk) begin
        if (bus.start === 1'b1 && bus.busy === 1'b1 && clr === 1'b0) begin
            fails++;
            $error("FAIL start_while_busy: observed start=1 busy=1 required no overlap");
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one op, from the instruction-set definitions.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] h, input logic [31:0] l,
                                  output logic [31:0] nh, output logic [31:0] nl, output int cyc);
        longint sa, sb, q, r;
        logic [63:0] ps, pu, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ps  = sa * sb;
        pu  = {32'd0, a} * {32'd0, b};
        acc = {h, l};
        nh  = h;
        nl  = l;
        cyc = 0;
        case (op)
            OP_MULT:  begin {nh, nl} = ps; cyc = 5; end
            OP_MULTU: begin {nh, nl} = pu; cyc = 5; end
            OP_DIV: begin
                cyc = 10;
                if (b != 32'd0) begin
                    q = sa / sb;
                    r = sa % sb;
                    nl = q[31:0];
                    nh = r[31:0];
                end
            end
            OP_DIVU: begin
                cyc = 10;
                if (b != 32'd0) begin
                    nl = a / b;
                    nh = a % b;
                end
            end
            OP_MTHI: nh = a;
            OP_MTLO: nl = a;
            OP_MADD:  if (MADD_EN) begin {nh, nl} = acc + ps; cyc = 5; end
            OP_MADDU: if (MADD_EN) begin {nh, nl} = acc + pu; cyc = 5; end
            OP_MSUB:  if (MADD_EN) begin {nh, nl} = acc - ps; cyc = 5; end
            OP_MSUBU: if (MADD_EN) begin {nh, nl} = acc - pu; cyc = 5; end
            default: cyc = 0;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] eh, el;
        int ecyc;
        int cyc;
        model(op, a, b, mhi, mlo, eh, el, ecyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 4'd0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 40) begin
            cyc++;
            check({tag, " hold"}, {bus.hi, bus.lo}, {mhi, mlo});
            @(posedge clk);
            #1;
        end
        check({tag, " cycles"}, 64'(cyc), 64'(ecyc));
        check({tag, " hilo"}, {bus.hi, bus.lo}, {eh, el});
        mhi = eh;
        mlo = el;
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        clr       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset hi", {32'd0, bus.hi}, 64'd0);
        check("reset lo", {32'd0, bus.lo}, 64'd0);
        check("reset busy", {63'd0, bus.busy}, 64'd0);
        clr = 1'b0;

        run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, "mult");
        check("mult const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFA);
        run_op(OP_MULTU, 32'hFFFFFFFE, 32'd3, "multu");
        check("multu const", {bus.hi, bus.lo}, 64'h00000002_FFFFFFFA);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, "div");
        check("div const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(OP_MTHI, 32'h11, 32'd0, "mthi11");
        run_op(OP_MTLO, 32'h22, 32'd0, "mtlo22");
        run_op(OP_DIVU, 32'd7, 32'd0, "divu0");
        check("divu0 const", {bus.hi, bus.lo}, 64'h00000011_00000022);
        run_op(OP_MTHI, 32'hDEADBEEF, 32'd0, "mthi");
        run_op(OP_MTLO, 32'h12345678, 32'd0, "mtlo");
        check("mthi/mtlo const", {bus.hi, bus.lo}, 64'hDEADBEEF_12345678);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, "div ovf");
        check("div ovf const", {bus.hi, bus.lo}, 64'h00000000_80000000);

        run_op(OP_MTHI, 32'd0, 32'd0, "mthi0");
        run_op(OP_MTLO, 32'hFFFFFFFF, 32'd0, "mtloF");
        run_op(OP_MADDU, 32'd1, 32'd1, "maddu");
        check("maddu const", {bus.hi, bus.lo},
              MADD_EN ? 64'h00000001_00000000 : 64'h00000000_FFFFFFFF);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 4) == 0) rb = 32'd0;
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h80000000;
                rb = 32'hFFFFFFFF;
            end
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            run_op(rop, ra, rb, $sformatf("rand%0d op%0d", i, rop));
        end

        run_op(OP_MTHI, 32'h55, 32'd0, "pre-abort");
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort busy before clr", {63'd0, bus.busy}, 64'd1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("abort busy", {63'd0, bus.busy}, 64'd0);
        check("abort hilo", {bus.hi, bus.lo}, 64'd0);
        repeat (15) @(posedge clk);
        #1;
        check("abort no late commit", {bus.hi, bus.lo}, 64'd0);
        check("abort busy later", {63'd0, bus.busy}, 64'd0);
        mhi = 32'd0;
        mlo = 32'd0;

        run_op(OP_MTHI, 32'h77, 32'd0, "pre-clrstart");
        @(negedge clk);
        clr       = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        @(posedge clk);
        #1;
        clr       = 1'b0;
        bus.start = 1'b0;
        bus.op    = 4'd0;
        check("clr+start hilo", {bus.hi, bus.lo}, 64'd0);
        @(posedge clk);
        #1;
        check("clr+start busy", {63'd0, bus.busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
